// File: rtl/riscv_alu_mdu.sv
// riscv_alu_mdu: handshaked EX-stage unit with the base RV ALU ops and optional M-extension
// (iterative radix-2 multiply, restoring divide). Every result is registered.
// Define RISCV_ALU_MDU_MEXT_EN to build the multiply/divide datapath; without it, M ops
// complete in one cycle and are flagged illegal.
module riscv_alu_mdu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            less_o,
    output logic            illegal_o
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            less_q, less_d;
    logic            illegal_q, illegal_d;

    logic            accept;
    logic [XLEN-1:0] alu_res;
    logic            alu_lt;
    logic [XLEN-1:0] alu_sra;

    // Loaded into the output registers when a result is produced.
    logic            load;
    logic [XLEN-1:0] res_new;
    logic            less_new;
    logic            ill_new;

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign accept      = in_valid_i && in_ready_o;
    assign result_o    = result_q;
    assign zero_o      = zero_q;
    assign less_o      = less_q;
    assign illegal_o   = illegal_q;

    // Kept separate so the arithmetic shift is not forced unsigned by a surrounding ternary.
    assign alu_sra = $signed(a_i) >>> b_i[SHAMT_W-1:0];

    // Single-cycle ALU on the live request operands.
    always_comb begin
        alu_lt  = op_i[3] ? (a_i < b_i) : ($signed(a_i) < $signed(b_i));
        alu_res = '0;
        unique case (op_i[2:0])
            3'b000: alu_res = op_i[3] ? (a_i - b_i) : (a_i + b_i);
            3'b001: alu_res = a_i << b_i[SHAMT_W-1:0];
            3'b010: alu_res = {{(XLEN-1){1'b0}}, alu_lt};
            3'b011: alu_res = b_i;
            3'b100: alu_res = a_i ^ b_i;
            3'b101: alu_res = op_i[3] ? alu_sra : (a_i >> b_i[SHAMT_W-1:0]);
            3'b110: alu_res = a_i | b_i;
            3'b111: alu_res = a_i & b_i;
            default: alu_res = '0;
        endcase
    end

`ifdef RISCV_ALU_MDU_MEXT_EN
    localparam logic [XLEN-1:0]    MinVal  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SHAMT_W-1:0] LastCnt = SHAMT_W'(XLEN - 1);

    // mul: {accumulator, multiplier}; div: {partial remainder, dividend/quotient}
    logic [2*XLEN-1:0] work_q, work_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [2:0]        mop_q, mop_d;
    logic              neg_q, neg_d;     // result needs negating at DONE
    logic [SHAMT_W-1:0] cnt_q, cnt_d;

    logic              a_sgn, b_sgn, a_neg, b_neg, m_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              spec_hit;
    logic [XLEN-1:0]   spec_res;
    logic [XLEN-1:0]   mul_add;
    logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
    logic [2*XLEN-1:0] step_w, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;

    // Operand signs/magnitudes and the div/rem corner cases that bypass iteration.
    always_comb begin
        a_sgn = (op_i[2:0] == 3'b001) || (op_i[2:0] == 3'b010) || (op_i[2] && !op_i[0]);
        b_sgn = (op_i[2:0] == 3'b001) || (op_i[2] && !op_i[0]);
        a_neg = a_sgn && a_i[XLEN-1];
        b_neg = b_sgn && b_i[XLEN-1];
        a_mag = a_neg ? -a_i : a_i;
        b_mag = b_neg ? -b_i : b_i;
        // Remainder follows the dividend sign; everything else is sa ^ sb.
        m_neg = (op_i[2:1] == 2'b11) ? a_neg : (a_neg ^ b_neg);
        spec_hit = 1'b0;
        spec_res = '0;
        if (op_i[2]) begin
            if (b_i == '0) begin
                spec_hit = 1'b1;
                spec_res = op_i[1] ? a_i : '1;
            end else if (!op_i[0] && (a_i == MinVal) && (b_i == '1)) begin
                spec_hit = 1'b1;
                spec_res = op_i[1] ? '0 : MinVal;
            end
        end
    end

    // One shift-add or restoring-subtract step, and the sign-fixed final result.
    always_comb begin
        mul_add  = work_q[0] ? opnd_q : '0;
        mul_sum  = {1'b0, work_q[2*XLEN-1:XLEN]} + {1'b0, mul_add};
        rem_sh   = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, opnd_q};
        if (!mop_q[2]) begin
            step_w = {mul_sum, work_q[XLEN-1:1]};
        end else if (!rem_diff[XLEN]) begin
            step_w = {rem_diff[XLEN-1:0], work_q[XLEN-2:0], 1'b1};
        end else begin
            step_w = {rem_sh[XLEN-1:0], work_q[XLEN-2:0], 1'b0};
        end
        prod_fix = neg_q ? -step_w : step_w;
        quo_fix  = neg_q ? -step_w[XLEN-1:0] : step_w[XLEN-1:0];
        rem_fix  = neg_q ? -step_w[2*XLEN-1:XLEN] : step_w[2*XLEN-1:XLEN];
        if (!mop_q[2]) begin
            fin_res = (mop_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else begin
            fin_res = mop_q[1] ? rem_fix : quo_fix;
        end
    end

    // Iterative datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            work_q <= '0;
            opnd_q <= '0;
            mop_q  <= '0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            work_q <= work_d;
            opnd_q <= opnd_d;
            mop_q  <= mop_d;
            neg_q  <= neg_d;
            cnt_q  <= cnt_d;
        end
    end
`endif

    // Handshake FSM and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        less_d    = less_q;
        illegal_d = illegal_q;
        load      = 1'b0;
        res_new   = '0;
        less_new  = 1'b0;
        ill_new   = 1'b0;
`ifdef RISCV_ALU_MDU_MEXT_EN
        work_d = work_q;
        opnd_d = opnd_q;
        mop_d  = mop_q;
        neg_d  = neg_q;
        cnt_d  = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!op_i[4]) begin
                        load     = 1'b1;
                        res_new  = alu_res;
                        less_new = (op_i[2:0] == 3'b010) && alu_res[0];
                        state_d  = StDone;
                    end else begin
`ifdef RISCV_ALU_MDU_MEXT_EN
                        if (spec_hit) begin
                            load    = 1'b1;
                            res_new = spec_res;
                            state_d = StDone;
                        end else begin
                            work_d  = {{XLEN{1'b0}}, (op_i[2] ? a_mag : b_mag)};
                            opnd_d  = op_i[2] ? b_mag : a_mag;
                            mop_d   = op_i[2:0];
                            neg_d   = m_neg;
                            cnt_d   = '0;
                            state_d = StCalc;
                        end
`else
                        load    = 1'b1;
                        res_new = '0;
                        ill_new = 1'b1;
                        state_d = StDone;
`endif
                    end
                end
            end
            StCalc: begin
`ifdef RISCV_ALU_MDU_MEXT_EN
                work_d = step_w;
                cnt_d  = cnt_q + SHAMT_W'(1);
                if (cnt_q == LastCnt) begin
                    load    = 1'b1;
                    res_new = fin_res;
                    state_d = StDone;
                end
`else
                state_d = StIdle;
`endif
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d   = StIdle;
                    illegal_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (load) begin
            result_d  = res_new;
            zero_d    = (res_new == '0);
            less_d    = less_new;
            illegal_d = ill_new;
        end
    end

    // State and output registers; reset aborts any in-flight operation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            result_q  <= '0;
            zero_q    <= 1'b0;
            less_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            less_q    <= less_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_riscv_alu_mdu.sv
// Self-checking bench for riscv_alu_mdu (XLEN=32); follows RISCV_ALU_MDU_MEXT_EN like the DUT.
`timescale 1ns/1ps
module tb_riscv_alu_mdu;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [4:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        less_o;
    logic        illegal_o;

    int n_vec = 0;
    int n_err = 0;

`ifdef RISCV_ALU_MDU_MEXT_EN
    localparam int MLat = 33;
`else
    localparam int MLat = 1;
`endif

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        l;
        logic        il;
        int          lat;
    } dvec_t;

    riscv_alu_mdu #(.XLEN(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_i        (op_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .zero_o      (zero_o),
        .less_o      (less_o),
        .illegal_o   (illegal_o)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the RISC-V op definitions.
    function automatic void model(input logic [4:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic l, output logic il, output int lat);
        int sa, sb;
        longint la, lb, lbu, p;
        longint unsigned pu;
        sa = a;
        sb = b;
        la = longint'(sa);
        lb = longint'(sb);
        lbu = longint'({32'd0, b});
        r = '0; l = 1'b0; il = 1'b0; lat = 1;
        if (!op[4]) begin
            case (op[2:0])
                3'd0: r = op[3] ? a - b : a + b;
                3'd1: r = a << b[4:0];
                3'd2: begin l = op[3] ? (a < b) : (sa < sb); r = {31'd0, l}; end
                3'd3: r = b;
                3'd4: r = a ^ b;
                3'd5: begin
                    if (op[3]) begin sa = sa >>> b[4:0]; r = sa; end
                    else r = a >> b[4:0];
                end
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else begin
`ifdef RISCV_ALU_MDU_MEXT_EN
            lat = 33;
            case (op[2:0])
                3'd0: begin p = la * lb; r = p[31:0]; end
                3'd1: begin p = la * lb; r = p[63:32]; end
                3'd2: begin p = la * lbu; r = p[63:32]; end
                3'd3: begin pu = {32'd0, a} * {32'd0, b}; r = pu[63:32]; end
                3'd4: begin
                    if (b == 0) begin r = '1; lat = 1; end
                    else if (a == 32'h8000_0000 && b == '1) begin r = a; lat = 1; end
                    else r = sa / sb;
                end
                3'd5: begin
                    if (b == 0) begin r = '1; lat = 1; end
                    else r = a / b;
                end
                3'd6: begin
                    if (b == 0) begin r = a; lat = 1; end
                    else if (a == 32'h8000_0000 && b == '1) begin r = 0; lat = 1; end
                    else r = sa % sb;
                end
                default: begin
                    if (b == 0) begin r = a; lat = 1; end
                    else r = a % b;
                end
            endcase
`else
            il = 1'b1;
`endif
        end
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one request from IDLE, wait (bounded) for the result, then complete the handshake.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic z, output logic l,
                          output logic il, output int lat);
        op_i = op; a_i = a; b_i = b; in_valid_i = 1'b1; out_ready_i = 1'b1;
        @(posedge clk); #1;
        // Scramble the inputs so that unlatched operands would show up.
        in_valid_i = 1'b0; op_i = 5'($urandom); a_i = $urandom; b_i = $urandom;
        lat = 1;
        while (!out_valid_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        r = result_o; z = zero_o; l = less_o; il = illegal_o;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
        op_i = '0; a_i = '0; b_i = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({in_ready_o, out_valid_o, result_o, zero_o, less_o, illegal_o} !== {2'b10, 32'd0, 3'b000}) begin
            n_err++;
            $display("FAIL reset: rdy=%b vld=%b r=%h z=%b l=%b il=%b, want rdy=1 vld=0 r=0 z=0 l=0 il=0",
                     in_ready_o, out_valid_o, result_o, zero_o, less_o, illegal_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_directed();
        dvec_t v[$];
        logic [31:0] r; logic z, l, il; int lat;
        v.push_back('{5'b01000, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1});
        v.push_back('{5'b01000, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 1});
        v.push_back('{5'b00010, 32'h8000_0000, 32'd1, 32'd1, 1'b1, 1'b0, 1});
        v.push_back('{5'b01010, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b0, 1});
        v.push_back('{5'b01101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 1});
        v.push_back('{5'b00101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0, 1});
        v.push_back('{5'b00001, 32'h0000_0003, 32'd33, 32'h0000_0006, 1'b0, 1'b0, 1});
`ifdef RISCV_ALU_MDU_MEXT_EN
        v.push_back('{5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 33});
        v.push_back('{5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 33});
        v.push_back('{5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 33});
        v.push_back('{5'b10000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0, 1'b0, 33});
        v.push_back('{5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1});
        v.push_back('{5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1});
        v.push_back('{5'b10101, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1});
        v.push_back('{5'b10111, 32'd7, 32'd0, 32'd7, 1'b0, 1'b0, 1});
        v.push_back('{5'b10110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, 33});
        v.push_back('{5'b10100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0, 33});
        v.push_back('{5'b10101, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33});
`else
        v.push_back('{5'b10000, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 1});
        v.push_back('{5'b10100, 32'd9, 32'd0, 32'd0, 1'b0, 1'b1, 1});
`endif
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, r, z, l, il, lat);
            n_vec++;
            if ({r, z, l, il, lat} !== {v[i].r, (v[i].r == 32'd0), v[i].l, v[i].il, v[i].lat}) begin
                n_err++;
                $display("FAIL directed[%0d] op=%b a=%h b=%h: got r=%h z=%b l=%b il=%b lat=%0d, want r=%h z=%b l=%b il=%b lat=%0d",
                         i, v[i].op, v[i].a, v[i].b, r, z, l, il, lat,
                         v[i].r, (v[i].r == 32'd0), v[i].l, v[i].il, v[i].lat);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] op; logic [31:0] a, b, r, er; logic z, l, il, el, eil; int lat, elat;
        for (int i = 0; i < 250; i++) begin
            op = 5'($urandom);
            a = pick_val();
            b = pick_val();
            model(op, a, b, er, el, eil, elat);
            run_op(op, a, b, r, z, l, il, lat);
            n_vec++;
            if ({r, z, l, il, lat} !== {er, (er == 32'd0), el, eil, elat}) begin
                n_err++;
                $display("FAIL random[%0d] op=%b a=%h b=%h: got r=%h z=%b l=%b il=%b lat=%0d, want r=%h z=%b l=%b il=%b lat=%0d",
                         i, op, a, b, r, z, l, il, lat, er, (er == 32'd0), el, eil, elat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] op; logic [31:0] a, b, er; logic el, eil; int elat, w;
        op = 5'b10011;   // mulhu, or an illegal op without M
        a = $urandom; b = $urandom;
        model(op, a, b, er, el, eil, elat);
        op_i = op; a_i = a; b_i = b; in_valid_i = 1'b1; out_ready_i = 1'b0;
        @(posedge clk); #1;
        in_valid_i = 1'b0; a_i = ~a;
        w = 1;
        while (!out_valid_o && w < 100) begin @(posedge clk); #1; w++; end
        n_vec++;
        if (w !== MLat) begin
            n_err++;
            $display("FAIL bp_latency: got %0d cycles, want %0d", w, MLat);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if ({out_valid_o, in_ready_o, result_o, illegal_o} !== {2'b10, er, eil}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: vld=%b rdy=%b r=%h il=%b, want vld=1 rdy=0 r=%h il=%b",
                         k, out_valid_o, in_ready_o, result_o, illegal_o, er, eil);
            end
        end
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({out_valid_o, in_ready_o, illegal_o} !== 3'b010) begin
            n_err++;
            $display("FAIL bp_release: vld=%b rdy=%b il=%b, want vld=0 rdy=1 il=0",
                     out_valid_o, in_ready_o, illegal_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] op [9]; logic [31:0] a [9], b [9], er; logic el, eil; int elat;
        for (int k = 0; k < 9; k++) begin
            op[k] = {1'b0, 4'($urandom)};
            a[k] = $urandom;
            b[k] = $urandom;
        end
        out_ready_i = 1'b1;
        op_i = op[0]; a_i = a[0]; b_i = b[0]; in_valid_i = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            model(op[k], a[k], b[k], er, el, eil, elat);
            n_vec++;
            if ({out_valid_o, in_ready_o, result_o, less_o} !== {2'b10, er, el}) begin
                n_err++;
                $display("FAIL b2b_done[%0d]: vld=%b rdy=%b r=%h l=%b, want vld=1 rdy=0 r=%h l=%b",
                         k, out_valid_o, in_ready_o, result_o, less_o, er, el);
            end
            // Next request is already presented but must wait for IDLE.
            op_i = op[k+1]; a_i = a[k+1]; b_i = b[k+1]; in_valid_i = (k < 7);
            @(posedge clk); #1;
            n_vec++;
            if ({out_valid_o, in_ready_o} !== 2'b01) begin
                n_err++;
                $display("FAIL b2b_idle[%0d]: vld=%b rdy=%b, want vld=0 rdy=1", k, out_valid_o, in_ready_o);
            end
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic z, l, il; int lat; bit seen;
`ifdef RISCV_ALU_MDU_MEXT_EN
        op_i = 5'b10101; a_i = 32'd1000; b_i = 32'd3;   // divu, iterative
        out_ready_i = 1'b1;
`else
        op_i = 5'b00000; a_i = 32'd40; b_i = 32'd2;     // held in DONE instead
        out_ready_i = 1'b0;
`endif
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        n_vec++;
        if ({out_valid_o, in_ready_o, result_o} !== {2'b01, 32'd0}) begin
            n_err++;
            $display("FAIL mid_reset: vld=%b rdy=%b r=%h, want vld=0 rdy=1 r=0", out_valid_o, in_ready_o, result_o);
        end
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid_o) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL aborted_result: out_valid seen=%b, want 0", seen);
        end
        run_op(5'b00000, 32'd1, 32'd2, r, z, l, il, lat);
        n_vec++;
        if ({r, z, l, il, lat} !== {32'd3, 3'b000, 1}) begin
            n_err++;
            $display("FAIL post_reset_add: got r=%h z=%b l=%b il=%b lat=%0d, want r=00000003 z=0 l=0 il=0 lat=1",
                     r, z, l, il, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1, "watchdog expired");
    end

endmodule
